// File: rtl/tipi_speech_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tipi_speech_pkg
// Description : Shared constants for the TIPI speech write buffer.
//               - SPCH_WR_ADDR / SPCH_RD_ADDR : TI bus decode addresses
//               - ST_TS/ST_BL/ST_BE/ST_OV     : bit positions in the status
//                 byte (bit 0 is the MSB of the TI data bus)
// Revision    : 1.0  initial release
// ============================================================================
package tipi_speech_pkg;

  localparam logic [15:0] SPCH_WR_ADDR = 16'h9400;
  localparam logic [15:0] SPCH_RD_ADDR = 16'h9000;

  localparam int ST_TS = 0;
  localparam int ST_BL = 1;
  localparam int ST_BE = 2;
  localparam int ST_OV = 3;

endpackage : tipi_speech_pkg
`default_nettype wire

// File: rtl/tipi_speech_fifo_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer for an asynchronous level, with a
//               registered single-cycle pulse on each rising edge of the
//               synchronized level.
// Ports       : clk      - destination clock
//               rst      - asynchronous active-high reset
//               i_async  - asynchronous input level
//               o_level  - synchronized level
//               o_rise   - one-cycle pulse, registered, on each rising edge
// Revision    : 1.0  initial release
// ============================================================================
module sync_edge
  import tipi_speech_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      // Pulse is registered so the edge is visible one edge after the
      // synchronized level rises.
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_rise;

endmodule : sync_edge
`default_nettype wire

// File: rtl/tipi_speech_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tipi_speech_fifo
// Description : Speech-side write buffer for the TI expansion bus. TI byte
//               writes to >9400 are queued in a DEPTH-entry FIFO which the
//               RPi drains with a pop strobe. TI reads of >9000 return a
//               TMS5220-style status byte (TS, BL, BE, OV).
// Config      : TIPI_SPEECH_IRQ_EN - when defined, spch_irq raises on the
//               BL 0->1 transition and clears at the end of a status read;
//               otherwise spch_irq is tied low.
// Ports       : ti_ph3        - TI phase-3 clock (sole clock)
//               ti_reset      - asynchronous active-high reset
//               ti_a          - TI address, bit 0 MSB
//               ti_memen      - memory enable, active low
//               ti_we         - write strobe, active low
//               ti_dbin       - read strobe, active high
//               tp_d_in       - TI write data
//               spch_d_out    - status byte toward TI bus
//               spch_d_oe     - drive enable for spch_d_out
//               rpi_pop       - RPi pop request (async, rising edge pops)
//               rpi_talk      - RPi speaking flag (async)
//               fifo_head     - oldest entry, registered
//               fifo_count    - occupancy 0..DEPTH
//               fifo_empty    - occupancy is zero
//               spch_overflow - sticky, set when a write is dropped
//               spch_irq      - buffer-low interrupt request
// Revision    : 1.0  initial release
// ============================================================================
module tipi_speech_fifo
  import tipi_speech_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BL_THRESH = 8
) (
  input  logic        ti_ph3,
  input  logic        ti_reset,
  input  logic [0:15] ti_a,
  input  logic        ti_memen,
  input  logic        ti_we,
  input  logic        ti_dbin,
  input  logic [0:7]  tp_d_in,
  output logic [0:7]  spch_d_out,
  output logic        spch_d_oe,
  input  logic        rpi_pop,
  input  logic        rpi_talk,
  output logic [0:7]  fifo_head,
  output logic [0:AW] fifo_count,
  output logic        fifo_empty,
  output logic        spch_overflow,
  output logic        spch_irq
);

  localparam logic [AW:0] c_full      = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_bl_thresh = (AW+1)'(BL_THRESH);

  logic          r_we_q;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [0:7]    r_head;
  logic [0:7]    r_mem [DEPTH];
  logic          r_ovf;
  logic          r_rd_act;
  logic [0:7]    r_status;

  logic          w_push;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic          w_bl;
  logic          w_talk;
  logic          w_rd_act;
  logic          w_rd_done;
  logic [AW-1:0] w_rptr_nxt;
  logic [0:7]    w_head_nxt;
  logic [0:7]    w_status_live;
  logic          w_pop_level;
  logic          w_talk_rise;
  logic          w_unused_sync;

  // --------------------------------------------------------------------------
  // RPi-side strobes
  // --------------------------------------------------------------------------
  sync_edge u_pop_sync (
    .clk     (ti_ph3),
    .rst     (ti_reset),
    .i_async (rpi_pop),
    .o_level (w_pop_level),
    .o_rise  (w_pop_req)
  );

  sync_edge u_talk_sync (
    .clk     (ti_ph3),
    .rst     (ti_reset),
    .i_async (rpi_talk),
    .o_level (w_talk),
    .o_rise  (w_talk_rise)
  );

  assign w_unused_sync = w_pop_level ^ w_talk_rise;

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  // Only the falling edge of ti_we pushes, so a long-held write and a write
  // already underway at reset release are both ignored after the first cycle.
  assign w_push  = r_we_q & ~ti_we & ~ti_memen & (ti_a == SPCH_WR_ADDR);
  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  assign w_bl    = (r_count <= c_bl_thresh);

  assign w_pop     = w_pop_req & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO lands.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_comb begin
    w_rptr_nxt = r_rptr;
    if (w_pop) begin
      w_rptr_nxt = r_rptr + AW'(1);
    end
    // Bypass the incoming byte when it lands in the slot that becomes head.
    w_head_nxt = r_mem[w_rptr_nxt];
    if (w_push_ok && (r_wptr == w_rptr_nxt)) begin
      w_head_nxt = tp_d_in;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  always_ff @(posedge ti_ph3) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= tp_d_in;
    end
  end

  always_ff @(posedge ti_ph3 or posedge ti_reset) begin
    if (ti_reset) begin
      r_we_q  <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= 8'h00;
    end else begin
      r_we_q <= ti_we;
      r_rptr <= w_rptr_nxt;
      r_head <= w_head_nxt;
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status read
  // --------------------------------------------------------------------------
  assign w_rd_act  = ~ti_memen & ti_dbin & (ti_a == SPCH_RD_ADDR);
  assign w_rd_done = r_rd_act & ~w_rd_act;

  always_comb begin
    w_status_live        = 8'h00;
    w_status_live[ST_TS] = w_talk;
    w_status_live[ST_BL] = w_bl;
    w_status_live[ST_BE] = w_empty;
    w_status_live[ST_OV] = r_ovf;
  end

  always_ff @(posedge ti_ph3 or posedge ti_reset) begin
    if (ti_reset) begin
      r_rd_act <= 1'b0;
      r_status <= 8'h00;
      r_ovf    <= 1'b0;
    end else begin
      r_rd_act <= w_rd_act;
      if (w_rd_act && !r_rd_act) begin
        r_status <= w_status_live;
      end
      // A drop coinciding with the read completion stays visible.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_rd_done) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // First read cycle shows the live value; later cycles show the frozen copy.
  assign spch_d_out = r_rd_act ? r_status : w_status_live;
  assign spch_d_oe  = w_rd_act & ~ti_reset;

  // --------------------------------------------------------------------------
  // Buffer-low interrupt
  // --------------------------------------------------------------------------
`ifdef TIPI_SPEECH_IRQ_EN
  logic r_bl_q;
  logic r_irq;

  always_ff @(posedge ti_ph3 or posedge ti_reset) begin
    if (ti_reset) begin
      // Reset count is 0 (BL=1), so start high to avoid a spurious edge.
      r_bl_q <= 1'b1;
      r_irq  <= 1'b0;
    end else begin
      r_bl_q <= w_bl;
      if (w_bl && !r_bl_q) begin
        r_irq <= 1'b1;
      end else if (w_rd_done) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign spch_irq = r_irq;
`else
  assign spch_irq = 1'b0;
`endif

  assign fifo_head     = r_head;
  assign fifo_count    = r_count;
  assign fifo_empty    = w_empty;
  assign spch_overflow = r_ovf;

endmodule : tipi_speech_fifo
`default_nettype wire

// File: tb/tb_tipi_speech_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_tipi_speech_fifo
// Description : Self-checking bench for tipi_speech_fifo. Stimulus queues the
//               expected popped bytes and status bytes; a monitor compares
//               them whenever the DUT pops an entry or starts a status read.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tipi_speech_fifo;
  import tipi_speech_pkg::*;

`ifdef TIPI_SPEECH_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        r_clk = 1'b0;
  logic        ti_reset;
  logic [0:15] ti_a;
  logic        ti_memen;
  logic        ti_we;
  logic        ti_dbin;
  logic [0:7]  tp_d_in;
  logic [0:7]  spch_d_out;
  logic        spch_d_oe;
  logic        rpi_pop;
  logic        rpi_talk;
  logic [0:7]  fifo_head;
  logic [0:4]  fifo_count;
  logic        fifo_empty;
  logic        spch_overflow;
  logic        spch_irq;

  logic [7:0]  exp_q  [$];
  logic [7:0]  stat_q [$];
  logic        m_ovf;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 r_clk = ~r_clk;

  tipi_speech_fifo dut (
    .ti_ph3        (r_clk),
    .ti_reset      (ti_reset),
    .ti_a          (ti_a),
    .ti_memen      (ti_memen),
    .ti_we         (ti_we),
    .ti_dbin       (ti_dbin),
    .tp_d_in       (tp_d_in),
    .spch_d_out    (spch_d_out),
    .spch_d_oe     (spch_d_oe),
    .rpi_pop       (rpi_pop),
    .rpi_talk      (rpi_talk),
    .fifo_head     (fifo_head),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .spch_overflow (spch_overflow),
    .spch_irq      (spch_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge r_clk);
    #2;
  endtask

  task automatic ti_write(input logic [15:0] addr, input logic [7:0] d, input int hold);
    ti_a = addr; tp_d_in = d; ti_memen = 1'b0; ti_we = 1'b0;
    if (addr == SPCH_WR_ADDR) begin
      if (exp_q.size() < 16) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
    repeat (hold) cyc();
    ti_we = 1'b1; ti_memen = 1'b1; ti_a = 16'h0000;
    cyc();
  endtask

  task automatic pop_one();
    rpi_pop = 1'b1;
    repeat (3) cyc();
    rpi_pop = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic status_read(input logic [7:0] exp);
    stat_q.push_back(exp);
    ti_a = SPCH_RD_ADDR; ti_memen = 1'b0; ti_dbin = 1'b1;
    repeat (3) cyc();
    ti_dbin = 1'b0; ti_memen = 1'b1; ti_a = 16'h0000;
    repeat (2) cyc();
    m_ovf = 1'b0;
  endtask

  // Monitor: a pop is seen as a count decrease, or as a head change at
  // constant non-zero count (simultaneous push and pop).
  initial begin : monitor
    logic [0:4] prev_cnt;
    logic [0:7] prev_head;
    logic       prev_oe;
    logic [7:0] e;
    prev_cnt = '0; prev_head = '0; prev_oe = 1'b0;
    forever begin
      @(negedge r_clk);
      if (!ti_reset) begin
        if ((fifo_count < prev_cnt) ||
            (fifo_count == prev_cnt && fifo_count != 0 && fifo_head != prev_head)) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL pop_data: unexpected pop of %0h, expected none", prev_head);
          end else begin
            e = exp_q.pop_front();
            check("pop_data", 32'(prev_head), 32'(e));
          end
        end
        if (spch_d_oe && !prev_oe) begin
          if (stat_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL status: unexpected read %0h, expected none", spch_d_out);
          end else begin
            e = stat_q.pop_front();
            check("status", 32'(spch_d_out), 32'(e));
          end
        end
      end
      prev_cnt  = fifo_count;
      prev_head = fifo_head;
      prev_oe   = spch_d_oe;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    ti_reset = 1'b1; ti_a = '0; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0;
    tp_d_in = '0; rpi_pop = 1'b0; rpi_talk = 1'b0; m_ovf = 1'b0;
    repeat (3) cyc();
    check("rst_count", 32'(fifo_count), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_head", 32'(fifo_head), 32'h00);
    check("rst_ovf", 32'(spch_overflow), 0);
    check("rst_irq", 32'(spch_irq), 0);
    check("rst_oe", 32'(spch_d_oe), 0);
    ti_reset = 1'b0;
    repeat (2) cyc();

    // Basic ordering
    ti_write(16'h9400, 8'hA1, 1);
    ti_write(16'h9400, 8'hB2, 1);
    ti_write(16'h9400, 8'hC3, 1);
    check("three_count", 32'(fifo_count), 3);
    check("three_head", 32'(fifo_head), 32'hA1);
    repeat (3) pop_one();
    check("drain_empty", 32'(fifo_empty), 1);
    check("drain_count", 32'(fifo_count), 0);

    // Long write strobe and wrong address
    ti_write(16'h9400, 8'h5A, 10);
    check("long_we_count", 32'(fifo_count), 1);
    ti_write(16'h9402, 8'h77, 1);
    check("bad_addr_count", 32'(fifo_count), 1);
    pop_one();
    check("long_drain_count", 32'(fifo_count), 0);

    // Overflow
    for (int i = 0; i < 17; i++) ti_write(16'h9400, 8'h10 + 8'(i), 1);
    check("full_count", 32'(fifo_count), 16);
    check("full_ovf", 32'(spch_overflow), 32'(m_ovf));
    check("full_head", 32'(fifo_head), 32'h10);
    status_read(8'h10);
    check("ovf_cleared", 32'(spch_overflow), 0);

    // Push and pop in the same cycle while full
    exp_q.push_back(8'hE5);
    rpi_pop = 1'b1;
    repeat (3) cyc();
    ti_a = SPCH_WR_ADDR; tp_d_in = 8'hE5; ti_memen = 1'b0; ti_we = 1'b0;
    cyc();
    ti_we = 1'b1; ti_memen = 1'b1; ti_a = 16'h0000; rpi_pop = 1'b0;
    repeat (3) cyc();
    check("simul_count", 32'(fifo_count), 16);
    check("simul_ovf", 32'(spch_overflow), 0);
    check("simul_head", 32'(fifo_head), 32'h11);
    repeat (16) pop_one();
    check("simul_drain_empty", 32'(fifo_empty), 1);
    check("simul_drain_irq", 32'(spch_irq), 32'(IRQ_ON));
    status_read(8'h60);
    check("irq_clr0", 32'(spch_irq), 0);

    // Buffer-low interrupt
    for (int i = 0; i < 9; i++) ti_write(16'h9400, 8'h30 + 8'(i), 1);
    check("nine_irq", 32'(spch_irq), 0);
    pop_one();
    check("eight_count", 32'(fifo_count), 8);
    check("bl_irq", 32'(spch_irq), 32'(IRQ_ON));
    rpi_talk = 1'b1;
    repeat (3) cyc();
    status_read(8'hC0);
    check("irq_clr1", 32'(spch_irq), 0);
    rpi_talk = 1'b0;

    // Reset with entries held
    repeat (3) pop_one();
    check("pre_rst_count", 32'(fifo_count), 5);
    @(posedge r_clk);
    #2;
    ti_reset = 1'b1;
    #1;
    check("arst_count", 32'(fifo_count), 0);
    check("arst_empty", 32'(fifo_empty), 1);
    check("arst_oe", 32'(spch_d_oe), 0);
    exp_q.delete();
    repeat (2) cyc();
    ti_reset = 1'b0;
    cyc();
    pop_one();
    check("post_rst_count", 32'(fifo_count), 0);
    check("post_rst_empty", 32'(fifo_empty), 1);
    check("stat_q_drained", 32'(stat_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tipi_speech_fifo
`default_nettype wire
